// File: rtl/viterbi_traceback.sv
// Traceback stage of the K=9 Viterbi decoder: walks the trellis backwards from the
// best-metric state, stacks the recovered bits in a LIFO and replays them oldest-first.
module viterbi_traceback #(
  parameter int N_ST     = 256,
  parameter int ST_W     = 8,
  parameter int TB_DEPTH = 45
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic [ST_W-1:0]                i_min_st,
  input  logic [N_ST-1:0][ST_W-1:0]      i_bck_prv_st,
  input  logic                           i_td_empty,
  output logic                           o_tb_rd,
  output logic                           o_tb_busy,
  output logic                           o_dec_bit,
  output logic                           o_dec_vld,
  output logic                           o_tb_done
);

  typedef enum logic [1:0] {IDLE, TRACE, OUTPUT, DONE} state_t;

  localparam logic [5:0] LAST_CAP = 6'(TB_DEPTH - 1);

  state_t                state, state_nxt;
  logic [ST_W-1:0]       cur_st;
  logic [5:0]            cnt;
  logic [5:0]            rd_idx;
  logic [TB_DEPTH-1:0]   lifo;
  logic                  dec_bit_p0;
  logic                  dec_vld_p0;
  logic                  last_cap;
  logic                  capture;

  assign last_cap = (cnt == LAST_CAP);
  assign capture  = (state == TRACE) && !i_td_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = TRACE;
      TRACE:   if (i_td_empty || last_cap) state_nxt = OUTPUT;
      OUTPUT:  if (rd_idx == 6'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_tb_rd   = capture;
    o_tb_busy = (state != IDLE);
    o_tb_done = (state == DONE);
  end

  // Trace: one trellis column per cycle; the first replayed bit is launched on the
  // closing TRACE edge so the output strobe starts immediately after tracing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st     <= '0;
      cnt        <= '0;
      rd_idx     <= '0;
      dec_bit_p0 <= 1'b0;
      dec_vld_p0 <= 1'b0;
    end else begin
      dec_vld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            cur_st <= i_min_st;
            cnt    <= '0;
          end
        end
        TRACE: begin
          if (!i_td_empty) begin
            cur_st <= i_bck_prv_st[cur_st];
            cnt    <= cnt + 6'd1;
            if (last_cap) begin
              dec_vld_p0 <= 1'b1;
              dec_bit_p0 <= cur_st[ST_W-1];
              rd_idx     <= LAST_CAP;
            end
          end else if (cnt != 6'd0) begin
            dec_vld_p0 <= 1'b1;
            dec_bit_p0 <= lifo[cnt - 6'd1];
            rd_idx     <= cnt - 6'd1;
          end else begin
            rd_idx <= '0;
          end
        end
        OUTPUT: begin
          if (rd_idx != 6'd0) begin
            dec_vld_p0 <= 1'b1;
            dec_bit_p0 <= lifo[rd_idx - 6'd1];
            rd_idx     <= rd_idx - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) lifo[cnt] <= cur_st[ST_W-1];
  end

  assign o_dec_bit = dec_bit_p0;
  assign o_dec_vld = dec_vld_p0;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: full-depth runs, early-empty run, empty start,
// ignored restart while busy and mid-output reset.
module tb_viterbi_traceback;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_start;
  logic [7:0]            i_min_st;
  logic [255:0][7:0]     i_bck_prv_st;
  logic                  i_td_empty;
  logic                  o_tb_rd, o_tb_busy, o_dec_bit, o_dec_vld, o_tb_done;

  int total = 0;
  int bad   = 0;

  int          rd_cnt, vld_cnt, done_cnt, first_rd, last_rd, first_vld, last_vld, done_cyc;
  int          busy_after, post_activity;
  logic [63:0] bits;

  viterbi_traceback #(.N_ST(256), .ST_W(8), .TB_DEPTH(45)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_min_st     (i_min_st),
    .i_bck_prv_st (i_bck_prv_st),
    .i_td_empty   (i_td_empty),
    .o_tb_rd      (o_tb_rd),
    .o_tb_busy    (o_tb_busy),
    .o_dec_bit    (o_dec_bit),
    .o_dec_vld    (o_dec_vld),
    .o_tb_done    (o_tb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_prv_const(input logic [7:0] v);
    for (int s = 0; s < 256; s++) i_bck_prv_st[s] = v;
  endtask

  task automatic set_prv_shift();
    for (int s = 0; s < 256; s++) i_bck_prv_st[s] = {s[6:0], 1'b0};
  endtask

  // Accept a start at edge 0 and observe cycles 1..; cycle k is sampled #2 after edge k-1.
  task automatic run(input logic [7:0] ms, input int empty_after, input bit restart);
    rd_cnt = 0; vld_cnt = 0; done_cnt = 0; bits = '0;
    first_rd = -1; last_rd = -1; first_vld = -1; last_vld = -1; done_cyc = -1;
    busy_after = -1; post_activity = 0;
    i_min_st = ms;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      i_td_empty = (rd_cnt >= empty_after);
      i_start    = restart && (cyc == 1);
      #1;
      if (done_cyc >= 0 && (o_tb_rd || o_dec_vld || o_tb_done)) post_activity++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = o_tb_busy;
      if (o_tb_rd) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        rd_cnt++;
      end
      if (o_dec_vld) begin
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
        vld_cnt++;
        bits = {bits[62:0], o_dec_bit};
      end
      if (o_tb_done && done_cyc < 0) begin
        done_cyc = cyc;
        done_cnt++;
      end else if (o_tb_done) begin
        done_cnt++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(posedge clk); #1;
    end
    i_start    = 1'b0;
    i_td_empty = 1'b0;
    if (done_cyc < 0) chk("run_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_min_st = '0; i_td_empty = 1'b0;
    set_prv_const(8'h00);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_vld",  o_dec_vld, 1'b0);
    chk("rst_bit",  o_dec_bit, 1'b0);
    chk("rst_done", o_tb_done, 1'b0);
    chk("rst_rd",   o_tb_rd,   1'b0);
    chk("rst_busy", o_tb_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full run, all-zero trellis
    set_prv_const(8'h00);
    run(8'h00, 1000, 1'b0);
    chk("t1_rd_cnt",   rd_cnt,    45);
    chk("t1_first_rd", first_rd,  1);
    chk("t1_last_rd",  last_rd,   45);
    chk("t1_vld_cnt",  vld_cnt,   45);
    chk("t1_first_vld", first_vld, 46);
    chk("t1_last_vld", last_vld,  90);
    chk("t1_bits",     bits,      64'h0);
    chk("t1_done_cyc", done_cyc,  91);
    chk("t1_done_cnt", done_cnt,  1);
    chk("t1_busy_after", busy_after, 0);
    chk("t1_post",     post_activity, 0);

    // Shift-register trellis from A5: 37 zeros then 1,0,1,0,0,1,0,1
    set_prv_shift();
    run(8'hA5, 1000, 1'b0);
    chk("t2_vld_cnt", vld_cnt,  45);
    chk("t2_bits",    bits,     64'h00000000000000A5);
    chk("t2_done_cyc", done_cyc, 91);

    // Trellis runs dry after 10 columns
    set_prv_const(8'hFF);
    run(8'hFF, 10, 1'b0);
    chk("t3_rd_cnt",   rd_cnt,    10);
    chk("t3_last_rd",  last_rd,   10);
    chk("t3_vld_cnt",  vld_cnt,   10);
    chk("t3_first_vld", first_vld, 12);
    chk("t3_bits",     bits,      64'h3FF);
    chk("t3_done_cyc", done_cyc,  22);
    chk("t3_done_cnt", done_cnt,  1);

    // Empty from the start, with a start pulse while busy
    run(8'h3C, 0, 1'b1);
    chk("t4_rd_cnt",   rd_cnt,   0);
    chk("t4_vld_cnt",  vld_cnt,  0);
    chk("t4_done_cyc", done_cyc, 3);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy_after", busy_after, 0);
    chk("t4_post",     post_activity, 0);

    // Reset after five output bits
    set_prv_const(8'h00);
    i_min_st = 8'h00;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    vld_cnt = 0;
    for (int cyc = 1; cyc < 200 && vld_cnt < 5; cyc++) begin
      #1;
      if (o_dec_vld) vld_cnt++;
      if (vld_cnt < 5) begin
        @(posedge clk); #1;
      end
    end
    chk("t5_reached5", vld_cnt, 5);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("t5_vld",  o_dec_vld, 1'b0);
    chk("t5_busy", o_tb_busy, 1'b0);
    chk("t5_done", o_tb_done, 1'b0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      if (o_tb_done || o_dec_vld) done_cnt++;
    end
    chk("t5_quiet", done_cnt, 0);
    #(-2 + 2);

    set_prv_shift();
    run(8'hA5, 1000, 1'b0);
    chk("t5_rerun_vld",  vld_cnt,  45);
    chk("t5_rerun_bits", bits,     64'h00000000000000A5);
    chk("t5_rerun_done", done_cyc, 91);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Traceback stage of the K=9 (256-state) Viterbi decoder, directly downstream of the trellis-diagram memory.
- Starts from the minimum-metric state supplied by the ACS/path-metric stage.
- Walks backwards one trellis column per cycle, using the predecessor-state vector the trellis memory presents.
- Buffers the recovered bits in a LIFO and re-emits them in forward (oldest-first) time order with a valid strobe.

Parameters:
- N_ST, 256, number of trellis states
- ST_W, 8, state index width (log2 N_ST)
- TB_DEPTH, 45, maximum traceback steps per run (5*K)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- i_start  input  1  begin a traceback run; sampled only in IDLE
- i_min_st  input  ST_W  start state (best path metric); latched when i_start is accepted
- i_bck_prv_st  input  ST_W x N_ST  predecessor state of each state at the current trellis depth; combinational read from trellis memory
- i_td_empty  input  1  trellis memory has no further columns
- o_tb_rd  output  1  consume one trellis column this cycle; trellis memory steps its depth
- o_tb_busy  output  1  high whenever FSM is not IDLE
- o_dec_bit  output  1  decoded bit, valid when o_dec_vld=1
- o_dec_vld  output  1  decoded-bit strobe
- o_tb_done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst=1 at a clk edge): FSM to IDLE; cur_st=0, cnt=0.
  - o_dec_bit, o_dec_vld, o_tb_done = 0.
  - o_tb_rd and o_tb_busy are 0 because the FSM is in IDLE.
  - Reset mid-run aborts immediately; no further o_dec_vld; LIFO contents don't care.
- State convention: state i = {u, prv[7:1]}. The decoded bit for the transition into state s is s[ST_W-1].
- States: IDLE, TRACE, OUTPUT, DONE.
- IDLE: i_start=1 -> cur_st<=i_min_st, cnt<=0, go TRACE. i_start in any other state is ignored.
- TRACE:
  - o_tb_rd = (state==TRACE) && !i_td_empty (combinational).
  - If i_td_empty=1: no capture, go OUTPUT with n=cnt.
  - Otherwise:
    - lifo[cnt] <= cur_st[ST_W-1]
    - cur_st <= i_bck_prv_st[cur_st]
    - cnt <= cnt+1
  - If cnt==TB_DEPTH-1, that capture is the last one; go OUTPUT with n=TB_DEPTH.
- OUTPUT:
  - Emit lifo[n-1], lifo[n-2] ... lifo[0], one per cycle.
  - o_dec_bit and o_dec_vld are registered.
  - o_dec_vld is high for exactly n consecutive cycles.
  - First vld is the cycle after the last TRACE cycle.
  - If n==0, no vld is produced and the FSM goes straight to DONE.
- DONE: o_tb_done=1 for one cycle, which is the cycle after the last vld; then IDLE. A new i_start is accepted from the following cycle.
- Counter/index width: 6 bits, no wrap; cnt never exceeds TB_DEPTH.
- Latency for a full run with i_start accepted at edge 0:
  - o_tb_rd high cycles 1..45
  - o_dec_vld high cycles 46..90
  - o_tb_done at cycle 91
- Predecessor lookup uses the cur_st value of the current cycle (256:1 mux of ST_W bits).

Test Plan:
- All i_bck_prv_st[s]=0, i_min_st=0, i_start pulse -> o_tb_rd high 45 cycles; 45 vld bits all 0; o_tb_done at cycle 91; busy low after.
- i_bck_prv_st[s]={s[6:0],1'b0}, i_min_st=8'hA5 -> 45 vld bits: 37 zeros, then 1,0,1,0,0,1,0,1.
- i_td_empty driven high after 10 o_tb_rd cycles, i_min_st=8'hFF, prv[s]=8'hFF -> exactly 10 vld bits all 1; o_tb_rd low once empty; done pulse follows.
- i_td_empty=1 at start -> zero o_tb_rd, zero vld, o_tb_done one cycle after entering OUTPUT; second i_start while busy produces no extra run.
- rst=1 during OUTPUT after 5 bits -> o_dec_vld=0, o_tb_busy=0 next cycle; no done pulse; fresh i_start then runs a normal 45-bit traceback.
